// File: rtl/vt_systematic_encoder.sv
// Serial systematic Varshamov-Tenengolts encoder: scatters K data bits into an
// n-bit word, then sets the power-of-two parity positions so that sum(i*x_i) mod (n+1) == a.
module vt_systematic_encoder #(
   parameter int DATA_WIDTH = 32,
   parameter int n          = 10,
   parameter int a          = 0,
   localparam int M         = $clog2(n + 1),
   localparam int K         = n - M
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [K-1:0]          data_in,
   output logic [DATA_WIDTH-1:0] codeword,
   output int                    N,
   output logic                  busy,
   output logic                  done
);

   localparam int ACC_W = $clog2(2 * n + 1);
   localparam logic [ACC_W-1:0] MOD  = ACC_W'(n + 1);
   localparam logic [ACC_W:0]   A_W  = (ACC_W + 1)'(a);
   localparam logic [ACC_W:0]   MOD_W = (ACC_W + 1)'(n + 1);
   localparam logic [M-1:0]     LAST = M'(n);

   generate
      if (a < 0 || a > n) begin : g_bad_a
         $error("vt_systematic_encoder: a must lie in 0..n");
      end
      if (n > DATA_WIDTH) begin : g_bad_n
         $error("vt_systematic_encoder: n must not exceed DATA_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCUM, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [n-1:0]     work;
   logic [n-1:0]     fixed;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0] acc_next;
   logic [M-1:0]     pos;
   logic [M-1:0]     parity;
   logic             accept;
   logic             bit_cur;

   // Data bit j lands on the j-th lowest position that is not a power of two.
   function automatic logic [n-1:0] scatter(input logic [K-1:0] d);
      logic [n-1:0] w;
      int           j;
      w = '0;
      j = 0;
      for (int p = 1; p <= n; p++) begin
         if ((p & (p - 1)) != 0) begin
            w[p-1] = d[j];
            j++;
         end
      end
      return w;
   endfunction

   // (a - s) mod (n+1), computed one bit wider so a + n + 1 cannot wrap.
   function automatic logic [M-1:0] parity_value(input logic [ACC_W-1:0] s);
      logic [ACC_W:0] t;
      t = A_W + MOD_W - {1'b0, s};
      if (t >= MOD_W) t = t - MOD_W;
      return t[M-1:0];
   endfunction

   function automatic logic [n-1:0] place_parity(input logic [n-1:0] w,
                                                 input logic [M-1:0] d);
      logic [n-1:0] r;
      r = w;
      for (int b = 0; b < M; b++) r[(1 << b) - 1] = d[b];
      return r;
   endfunction

   assign accept   = start && (state == IDLE || state == DONE);
   assign bit_cur  = work[pos - 1'b1];
   assign acc_sum  = acc + ACC_W'(pos);
   assign acc_next = (acc_sum >= MOD) ? acc_sum - MOD : acc_sum;
   assign parity   = parity_value(acc);
   assign fixed    = place_parity(work, parity);

   assign busy = (state == ACCUM) || (state == FIX);
   assign done = (state == DONE);
   assign N    = n;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (pos == LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? ACCUM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         codeword <= '0;
         acc      <= '0;
         pos      <= '0;
      end else if (accept) begin
         acc <= '0;
         pos <= M'(1);
      end else if (state == ACCUM) begin
         if (bit_cur) acc <= acc_next;
         pos <= pos + 1'b1;
      end else if (state == FIX) begin
         codeword <= DATA_WIDTH'(fixed);
      end
   end

   // Working register carries no reset: it is always reloaded on acceptance.
   always_ff @(posedge clk) begin
      if (accept)             work <= scatter(data_in);
      else if (state == FIX)  work <= fixed;
   end

endmodule

// File: tb/tb_vt_systematic_encoder.sv
// Scoreboard bench for vt_systematic_encoder: two instances (a=0 and a=5) share
// stimulus; a monitor compares codewords, done timing, busy and syndromes.
module tb_vt_systematic_encoder;

   localparam int NL = 10;
   localparam int KL = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [KL-1:0] data_in = '0;
   logic [DW-1:0] cw0, cw1;
   int            n0, n1;
   logic          busy0, busy1, done0, done1;

   vt_systematic_encoder #(.DATA_WIDTH(DW), .n(NL), .a(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
      .codeword(cw0), .N(n0), .busy(busy0), .done(done0));

   vt_systematic_encoder #(.DATA_WIDTH(DW), .n(NL), .a(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
      .codeword(cw1), .N(n1), .busy(busy1), .done(done1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
      int            at;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   int            bs = -1;
   int            be = -1;
   int            last_k = 0;
   logic [DW-1:0] last0 = '0;
   logic [DW-1:0] last1 = '0;

   // Reference: whole-word syndrome, then parity as a modular difference.
   function automatic logic [DW-1:0] ref_cw(input logic [KL-1:0] d, input int tgt);
      int            x[1:NL];
      int            j, s, par;
      logic [DW-1:0] r;
      j = 0;
      s = 0;
      r = '0;
      for (int p = 1; p <= NL; p++) begin
         if ($countones(p) == 1) x[p] = 0;
         else begin
            x[p] = int'(d[j]);
            j++;
         end
         s += p * x[p];
      end
      par = ((tgt - s) % (NL + 1) + (NL + 1)) % (NL + 1);
      for (int b = 0; (1 << b) <= NL; b++) x[1 << b] = (par >> b) & 1;
      for (int p = 1; p <= NL; p++) r[p-1] = (x[p] != 0);
      return r;
   endfunction

   function automatic int syndrome(input logic [DW-1:0] c);
      int s;
      s = 0;
      for (int p = 1; p <= NL; p++) if (c[p-1]) s += p;
      return s % (NL + 1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   // Start is sampled at the next edge; the DUT accepts only if it is not busy now.
   task automatic pulse(input logic [KL-1:0] d);
      exp_t e;
      int   k;
      k       = cyc;
      start   = 1'b1;
      data_in = d;
      if (!(k >= bs && k <= be)) begin
         e.e0 = ref_cw(d, 0);
         e.e1 = ref_cw(d, 5);
         e.at = k + NL + 2;
         q.push_back(e);
         bs     = k + 1;
         be     = k + NL + 1;
         last_k = k;
      end
      step();
      start = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cyc >= 1) begin
         logic exp_busy, exp_done;
         exp_t e;
         exp_busy = (cyc >= bs && cyc <= be);
         exp_done = (q.size() > 0) && (q[0].at == cyc);
         check("busy0", 64'(busy0), 64'(exp_busy));
         check("busy1", 64'(busy1), 64'(exp_busy));
         check("done0", 64'(done0), 64'(exp_done));
         check("done1", 64'(done1), 64'(exp_done));
         if (exp_done) begin
            e = q.pop_front();
            check("codeword_a0", 64'(cw0), 64'(e.e0));
            check("codeword_a5", 64'(cw1), 64'(e.e1));
            check("syndrome_a0", 64'(syndrome(cw0)), 64'd0);
            check("syndrome_a5", 64'(syndrome(cw1)), 64'd5);
            last0 = e.e0;
            last1 = e.e1;
         end else begin
            check("hold_a0", 64'(cw0), 64'(last0));
            check("hold_a5", 64'(cw1), 64'(last1));
         end
      end
   end

   initial begin
      int perm[64];
      int k, r, tmp;

      repeat (3) step();
      rst_n = 1'b1;
      check("N0", 64'(n0), 64'(NL));
      check("N1", 64'(n1), 64'(NL));
      check("reset_cw0", 64'(cw0), 64'd0);

      // Directed patterns from the zero word and the all-ones word
      pulse(6'b000000);
      wait_until(last_k + NL + 3);
      pulse(6'b111111);
      wait_until(last_k + NL + 3);
      check("all_ones_cw", 64'(cw0), 64'h37C);

      // Back-to-back: second start lands in the done cycle
      pulse(6'b000001);
      k = last_k;
      wait_until(k + NL + 2);
      pulse(6'b111111);
      wait_until(last_k + NL + 3);

      // Start while busy is ignored
      pulse(6'b010101);
      k = last_k;
      wait_until(k + 5);
      pulse(6'b101010);
      wait_until(k + NL + 3);

      // Reset mid-operation aborts without a done pulse
      pulse(6'b111111);
      k = last_k;
      wait_until(k + 6);
      rst_n = 1'b0;
      step();
      q.delete();
      bs    = -1;
      be    = -1;
      last0 = '0;
      last1 = '0;
      rst_n = 1'b1;
      pulse(6'b101010);
      wait_until(last_k + NL + 3);

      // Random-order sweep over every data word, with random gaps and busy-time starts
      for (int i = 0; i < 64; i++) perm[i] = i;
      for (int i = 63; i > 0; i--) begin
         r       = int'($urandom_range(0, i));
         tmp     = perm[i];
         perm[i] = perm[r];
         perm[r] = tmp;
      end
      for (int i = 0; i < 64; i++) begin
         pulse(KL'(perm[i]));
         k = last_k;
         if ($urandom_range(0, 3) == 0) begin
            wait_until(k + 1 + int'($urandom_range(0, NL - 1)));
            pulse(KL'($urandom));
         end
         wait_until(k + NL + 2 + int'($urandom_range(0, 2)));
      end

      wait_until(cyc + 2 * NL);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
